// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter serialising accesses onto the shared word-paired RAM.
// One transaction at a time; completion is a one-cycle done pulse per port.
module mem_port_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 20,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_LOW  = 3'd2,
        S_WAIT_HIGH = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               cur_r;
    logic               last_grant_r;
    logic               grant_s;
    logic               limit_s;
    logic               to_hit_s;
    logic               capture_s;
    logic               mem_req_s;
    logic               done0_s;
    logic               done1_s;
    logic               err_s;

    // Under contention the port that was not served last wins.
    assign grant_s   = (req0 && req1) ? ~last_grant_r : req1;
    // The counter value seen in the last permitted wait cycle.
    assign limit_s   = (cnt_r == CNT_W'(TIMEOUT - 1));
    assign to_hit_s  = limit_s && (((state_r == S_WAIT_LOW) && mem_ready) ||
                                   ((state_r == S_WAIT_HIGH) && !mem_ready));
    assign capture_s = (state_r == S_WAIT_HIGH) && mem_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (mem_ready && (req0 || req1)) begin
                    state_s = S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: state_s = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (!mem_ready) begin
                    state_s = S_WAIT_HIGH;
                end else if (limit_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_WAIT_LOW;
                end
            end
            S_WAIT_HIGH: begin
                if (mem_ready || limit_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_WAIT_HIGH;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output decode from the next state so the pulses are registered alongside it.
    always_comb begin
        mem_req_s = 1'b0;
        done0_s   = 1'b0;
        done1_s   = 1'b0;
        err_s     = err | to_hit_s;
        if (state_s == S_ISSUE) begin
            mem_req_s = 1'b1;
        end else begin
            mem_req_s = 1'b0;
        end
        if (state_s == S_DONE) begin
            done0_s = ~cur_r;
            done1_s = cur_r;
        end else begin
            done0_s = 1'b0;
            done1_s = 1'b0;
        end
    end

    // Datapath: latched request, wait counter, captured read data, sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            err          <= 1'b0;
            cnt_r        <= '0;
            cur_r        <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            mem_req <= mem_req_s;
            done0   <= done0_s;
            done1   <= done1_s;
            err     <= err_s;
            case (state_r)
                S_IDLE: begin
                    if (state_s == S_ISSUE) begin
                        cur_r     <= grant_s;
                        mem_we    <= grant_s ? we1 : we0;
                        mem_addr  <= grant_s ? addr1 : addr0;
                        mem_wdata <= grant_s ? wdata1 : wdata0;
                    end
                end
                S_ISSUE: cnt_r <= '0;
                S_WAIT_LOW: begin
                    if (!mem_ready) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (capture_s && !cur_r) begin
                        rdata0 <= mem_rdata;
                    end
                    if (capture_s && cur_r) begin
                        rdata1 <= mem_rdata;
                    end
                end
                S_DONE: begin
                    last_grant_r <= cur_r;
                    mem_we       <= 1'b0;
                end
                default: cnt_r <= '0;
            endcase
        end
    end

endmodule
